dmem_responder: RTL

- Multi-cycle data-memory responder: the target side of the core's load/store data interface.
- Accepts one request at a time over a valid/ready handshake.
- Inserts a fixed number of wait states, performs a byte-enabled word write or a word read, then returns a response over a second valid/ready handshake.
- Replaces the combinational data memory when the core moves to a handshaked, multi-cycle memory path.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_array.sv | 35 +++
 rtl/dmem_responder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_pkg : shared types, constants and address check for dmem_responder
// | Rev 1.0  : initial release
// +----------------------------------------------------------------------+
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam int WORD_BYTES = 4;

    // Range limit is formed in 34 bits so a window ending at 2^32 does not wrap.
    function automatic logic addr_ok(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned depth);
        logic [33:0] lim;
        lim = {2'b00, base} + (34'(depth) * 34'(WORD_BYTES));
        return (addr[1:0] == 2'b00) && (addr >= base) && ({2'b00, addr} < lim);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_array : word storage, byte-enabled sync write, async read, no reset
// | Rev 1.0    : initial release
// +----------------------------------------------------------------------+
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (be_i[i]) begin
                    mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_responder : handshaked multi-cycle data memory with wait states
// | Rev 1.0        : initial release
// +----------------------------------------------------------------------+
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic             req_fire, rsp_fire, access_en, addr_good, arr_we;
    logic [IDX_W-1:0] arr_idx;
    logic [31:0]      arr_rdata;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // WAIT exits when the count reaches 1, or immediately if it entered at 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_STATES == 0) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ACCESS;
                    cnt_d   = 4'd0;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        access_en = (state_q == ACCESS);
    end

    assign req_fire  = req_valid && req_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign addr_good = addr_ok(addr_q, BASE_ADDR, DEPTH_WORDS);
    assign arr_idx   = IDX_W'((addr_q - BASE_ADDR) >> 2);
    assign arr_we    = access_en && we_q && addr_good;

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (access_en) begin
            err_d   = !addr_good;
            rdata_d = (addr_good && !we_q) ? arr_rdata : 32'd0;
        end else if (rsp_fire) begin
            rdata_d = 32'd0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            if (req_fire) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .be_i    (be_q),
        .idx_i   (arr_idx),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

endmodule
`default_nettype wire
